// File: rtl/wb_sequencer.sv
// Write-back sequencer: drives regdst/reg_write/wb_src/sp_op for RT/RD/JAL/ALT, PUSH and POP.
// Optional stack-bounds check in IDLE is enabled by defining WB_SP_CHECK_EN.
module wb_sequencer #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_req,
    input  logic [2:0]  wb_op,
    input  logic [31:0] sp_value,
    output logic [2:0]  regdst_sel,
    output logic        reg_write,
    output logic [1:0]  wb_src,
    output logic [1:0]  sp_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WB, S_PUSH_DEC, S_PUSH_MEM,
        S_POP_RD, S_POP_WB, S_POP_INC, S_FAIL
    } state_t;

    localparam logic [2:0] OP_RT   = 3'b000;
    localparam logic [2:0] OP_RD   = 3'b001;
    localparam logic [2:0] OP_JAL  = 3'b010;
    localparam logic [2:0] OP_ALT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] LAT_M1  = 3'(MEM_LAT - 1);

    state_t     r_state;
    logic [2:0] r_op;
    logic [2:0] r_cnt;

    state_t     w_nxt_state;
    logic [2:0] w_nxt_op;
    logic [2:0] w_nxt_cnt;
    logic       w_push_bad;
    logic       w_pop_bad;

    logic [2:0] w_regdst;
    logic       w_rw;
    logic [1:0] w_src;
    logic [1:0] w_spop;
    logic       w_mr;
    logic       w_mw;
    logic       w_done;
    logic       w_err;

`ifdef WB_SP_CHECK_EN
    assign w_push_bad = sp_value < 32'd4;
    assign w_pop_bad  = sp_value > 32'hFFFF_FFFB;
`else
    logic w_sp_unused;
    assign w_sp_unused = ^sp_value;
    assign w_push_bad  = 1'b0;
    assign w_pop_bad   = 1'b0;
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_op    = r_op;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (wb_req) begin
                    w_nxt_op = wb_op;
                    case (wb_op)
                        OP_RT, OP_RD, OP_JAL, OP_ALT: w_nxt_state = S_WB;
                        OP_PUSH: w_nxt_state = w_push_bad ? S_FAIL : S_PUSH_DEC;
                        OP_POP: begin
                            if (w_pop_bad) begin
                                w_nxt_state = S_FAIL;
                            end else begin
                                w_nxt_state = S_POP_RD;
                                w_nxt_cnt   = LAT_M1;
                            end
                        end
                        default: w_nxt_state = S_FAIL;
                    endcase
                end
            end
            S_PUSH_DEC: w_nxt_state = S_PUSH_MEM;
            S_POP_RD: begin
                // Counter stops at zero; the transition out replaces the decrement.
                if (r_cnt == 3'd0) w_nxt_state = S_POP_WB;
                else w_nxt_cnt = r_cnt - 3'd1;
            end
            S_POP_WB: w_nxt_state = S_POP_INC;
            default:  w_nxt_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        w_regdst = 3'b000;
        w_rw     = 1'b0;
        w_src    = 2'b00;
        w_spop   = 2'b00;
        w_mr     = 1'b0;
        w_mw     = 1'b0;
        w_done   = 1'b0;
        w_err    = 1'b0;
        case (w_nxt_state)
            S_WB: begin
                w_rw   = 1'b1;
                w_done = 1'b1;
                case (w_nxt_op)
                    OP_RD:   w_regdst = 3'b001;
                    OP_ALT:  w_regdst = 3'b011;
                    OP_JAL: begin
                        w_regdst = 3'b100;
                        w_src    = 2'b10;
                    end
                    default: w_regdst = 3'b000;
                endcase
            end
            S_PUSH_DEC: begin
                w_regdst = 3'b010;
                w_spop   = 2'b01;
                w_rw     = 1'b1;
            end
            S_PUSH_MEM: begin
                w_mw   = 1'b1;
                w_done = 1'b1;
            end
            S_POP_RD: w_mr = 1'b1;
            S_POP_WB: begin
                w_src = 2'b01;
                w_rw  = 1'b1;
            end
            S_POP_INC: begin
                w_regdst = 3'b010;
                w_spop   = 2'b10;
                w_rw     = 1'b1;
                w_done   = 1'b1;
            end
            S_FAIL: begin
                w_done = 1'b1;
                w_err  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_op       <= 3'b000;
            r_cnt      <= 3'b000;
            regdst_sel <= 3'b000;
            reg_write  <= 1'b0;
            wb_src     <= 2'b00;
            sp_op      <= 2'b00;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_op       <= w_nxt_op;
            r_cnt      <= w_nxt_cnt;
            regdst_sel <= w_regdst;
            reg_write  <= w_rw;
            wb_src     <= w_src;
            sp_op      <= w_spop;
            mem_read   <= w_mr;
            mem_write  <= w_mw;
            busy       <= (w_nxt_state != S_IDLE);
            done       <= w_done;
            err        <= w_err;
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer (MEM_LAT=3): each directed row pushes
// the outputs expected in that cycle; a negedge monitor pops and compares.
module tb_wb_sequencer;

    localparam int LAT = 3;

    logic        clk;
    logic        reset;
    logic        wb_req;
    logic [2:0]  wb_op;
    logic [31:0] sp_value;
    logic [2:0]  regdst_sel;
    logic        reg_write;
    logic [1:0]  wb_src;
    logic [1:0]  sp_op;
    logic        mem_read;
    logic        mem_write;
    logic        busy;
    logic        done;
    logic        err;

    wb_sequencer #(.MEM_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_req     (wb_req),
        .wb_op      (wb_op),
        .sp_value   (sp_value),
        .regdst_sel (regdst_sel),
        .reg_write  (reg_write),
        .wb_src     (wb_src),
        .sp_op      (sp_op),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {regdst[2:0], reg_write, wb_src[1:0], sp_op[1:0], mem_read, mem_write, busy, done, err}
    localparam logic [12:0] E0     = 13'b000_0_00_00_0_0_0_0_0;
    localparam logic [12:0] E_RT   = 13'b000_1_00_00_0_0_1_1_0;
    localparam logic [12:0] E_RD   = 13'b001_1_00_00_0_0_1_1_0;
    localparam logic [12:0] E_ALT  = 13'b011_1_00_00_0_0_1_1_0;
    localparam logic [12:0] E_JAL  = 13'b100_1_10_00_0_0_1_1_0;
    localparam logic [12:0] E_PDEC = 13'b010_1_00_01_0_0_1_0_0;
    localparam logic [12:0] E_PMEM = 13'b000_0_00_00_0_1_1_1_0;
    localparam logic [12:0] E_PRD  = 13'b000_0_00_00_1_0_1_0_0;
    localparam logic [12:0] E_PWB  = 13'b000_1_01_00_0_0_1_0_0;
    localparam logic [12:0] E_PINC = 13'b010_1_00_10_0_0_1_1_0;
    localparam logic [12:0] E_FAIL = 13'b000_0_00_00_0_0_1_1_1;

    localparam logic [2:0] RT = 3'b000, RD = 3'b001, JAL = 3'b010;
    localparam logic [2:0] ALT = 3'b011, PUSH = 3'b100, POP = 3'b101;

    logic [12:0] exp_q[$];
    int          row_q[$];
    int          total;
    int          bad;
    int          row;

    // Inputs set here are sampled at the next edge; exp is what the DUT
    // must show in the current cycle (result of the previous row).
    task automatic step(input logic rst, input logic req, input logic [2:0] op,
                        input logic [31:0] sp, input logic [12:0] exp);
        @(posedge clk);
        #1;
        reset    = rst;
        wb_req   = req;
        wb_op    = op;
        sp_value = sp;
        exp_q.push_back(exp);
        row_q.push_back(row);
        row++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [12:0] e;
            logic [12:0] g;
            int          r;
            e = exp_q.pop_front();
            r = row_q.pop_front();
            g = {regdst_sel, reg_write, wb_src, sp_op,
                 mem_read, mem_write, busy, done, err};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL row%0d outputs got=%b exp=%b", r, g, e);
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        row      = 0;
        reset    = 1'b0;
        wb_req   = 1'b1;
        wb_op    = RD;
        sp_value = 32'd0;

        // reset held with request pending, then RD
        step(0, 1, RD, 0, E0);
        step(0, 1, RD, 0, E0);
        step(1, 1, RD, 0, E0);
        step(1, 0, RT, 0, E_RD);
        // JAL; request in its done cycle ignored
        step(1, 1, JAL, 0, E0);
        step(1, 1, PUSH, 227, E_JAL);
        // PUSH; requests during it ignored
        step(1, 1, PUSH, 227, E0);
        step(1, 1, 3'b111, 227, E_PDEC);
        step(1, 1, 3'b111, 227, E_PMEM);
        step(1, 0, RT, 100, E0);
        // POP with 3-cycle read
        step(1, 1, POP, 100, E0);
        step(1, 0, RT, 100, E_PRD);
        step(1, 0, RT, 100, E_PRD);
        step(1, 0, RT, 100, E_PRD);
        step(1, 0, RT, 100, E_PWB);
        step(1, 0, RT, 100, E_PINC);
        // illegal ops
        step(1, 1, 3'b111, 100, E0);
        step(1, 1, 3'b110, 100, E_FAIL);
        step(1, 1, 3'b110, 100, E0);
        step(1, 0, RT, 100, E_FAIL);
        // RT and ALT
        step(1, 1, RT, 100, E0);
        step(1, 1, ALT, 100, E_RT);
        step(1, 1, ALT, 100, E0);
        step(1, 0, RT, 100, E_ALT);
        // reset during POP_RD abandons the sequence
        step(1, 1, POP, 100, E0);
        step(1, 0, RT, 100, E_PRD);
        step(0, 0, RT, 100, E_PRD);
        step(0, 0, RT, 100, E0);
        step(1, 0, RT, 100, E0);
        step(1, 0, RT, 100, E0);
        step(1, 0, RT, 100, E0);
`ifdef WB_SP_CHECK_EN
        // stack bounds: PUSH at sp=0 and POP at sp=FFFFFFFC fail
        step(1, 1, PUSH, 0, E0);
        step(1, 0, RT, 0, E_FAIL);
        step(1, 1, POP, 32'hFFFF_FFFC, E0);
        step(1, 0, RT, 0, E_FAIL);
        step(1, 1, PUSH, 4, E0);
        step(1, 0, RT, 0, E_PDEC);
        step(1, 0, RT, 0, E_PMEM);
`else
        // without the check, PUSH at sp=0 runs normally
        step(1, 1, PUSH, 0, E0);
        step(1, 0, RT, 0, E_PDEC);
        step(1, 0, RT, 0, E_PMEM);
        step(1, 1, POP, 32'hFFFF_FFFC, E0);
        step(1, 0, RT, 0, E_PRD);
        step(1, 0, RT, 0, E_PRD);
        step(1, 0, RT, 0, E_PRD);
        step(1, 0, RT, 0, E_PWB);
        step(1, 0, RT, 0, E_PINC);
`endif
        step(1, 0, RT, 0, E0);

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
